// File: rtl/conv_encoder_pkg.sv
// Shared definitions for the radix-4, K=9 convolutional encoder and its trellis consumers.
package conv_encoder_pkg;

  localparam int MAX_STATE_REG_NUM = 8;
  localparam int RADIX             = 4;
  localparam int STEP_BITS         = $clog2(RADIX);

  localparam logic [8:0] G0_DEF = 9'o561;
  localparam logic [8:0] G1_DEF = 9'o753;

  // One radix-4 step shifts two zeros in, so half the state width flushes the trellis.
  localparam int TAIL_STEPS_DEF = MAX_STATE_REG_NUM / STEP_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    TAIL = 2'd2
  } enc_state_t;

  typedef struct packed {
    logic [3:0]                   code;
    logic [MAX_STATE_REG_NUM-1:0] state;
  } conv_step_t;

endpackage

// File: rtl/conv_encoder_step.sv
// Combinational radix-4 trellis step: (state, {d1,d0}) -> ({c3,c2,c1,c0}, next state).
module conv_encoder_step
  import conv_encoder_pkg::*;
#(
  parameter logic [8:0] G0 = G0_DEF,
  parameter logic [8:0] G1 = G1_DEF
) (
  input  logic [7:0] i_state,
  input  logic [1:0] i_d,
  output conv_step_t o_step
);

  logic [8:0] w_v0;
  logic [7:0] w_s1;
  logic [8:0] w_v1;

  // Bit 0 of each window is the newest bit, matching generator tap k at position k.
  assign w_v0 = {i_state, i_d[0]};
  assign w_s1 = {i_state[6:0], i_d[0]};
  assign w_v1 = {w_s1, i_d[1]};

  assign o_step.code  = {^(G1 & w_v1), ^(G0 & w_v1), ^(G1 & w_v0), ^(G0 & w_v0)};
  assign o_step.state = {i_state[5:0], i_d[0], i_d[1]};

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=9 radix-4 convolutional encoder with a single output register stage.
// Define CONV_TAIL_EN to append zero-tail steps so every frame terminates in state 0.
module conv_encoder
  import conv_encoder_pkg::*;
#(
  parameter logic [8:0] G0 = G0_DEF,
`ifdef CONV_TAIL_EN
  parameter int TAIL_STEPS = TAIL_STEPS_DEF,
`endif
  parameter logic [8:0] G1 = G1_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_enc,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_data,
  input  logic        i_last,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [3:0]  o_code,
  output logic        o_last,
  output logic [7:0]  o_state,
  output logic [15:0] o_step_cnt
);

  enc_state_t r_fsm, w_fsm_nxt;

  logic [7:0]  r_enc_st;
  logic        r_valid;
  logic [3:0]  r_code;
  logic        r_last;
  logic [7:0]  r_state;
  logic [15:0] r_cnt;

  logic       w_slot;
  logic       w_in_phase;
  logic       w_acc;
  logic       w_tail_iss;
  logic       w_tail_end;
  logic       w_issue;
  logic       w_last_step;
  logic [1:0] w_d;
  conv_step_t w_step;
  enc_state_t w_end_fsm;

  // A step may issue whenever the output register is empty or being drained.
  assign w_slot     = rst && en_enc && (!r_valid || i_ready);
  assign w_in_phase = (r_fsm == IDLE) || (r_fsm == ENC);
  assign o_ready    = w_slot && w_in_phase;
  assign w_acc      = i_valid && o_ready;

`ifdef CONV_TAIL_EN
  localparam int TCW = (TAIL_STEPS > 1) ? $clog2(TAIL_STEPS) : 1;

  logic [TCW-1:0] r_tail_cnt;

  assign w_tail_iss  = w_slot && (r_fsm == TAIL);
  assign w_tail_end  = w_tail_iss && (r_tail_cnt == TCW'(TAIL_STEPS - 1));
  assign w_last_step = w_tail_end;
  assign w_end_fsm   = TAIL;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_tail_cnt <= '0;
    else if (w_tail_iss) r_tail_cnt <= w_tail_end ? '0 : r_tail_cnt + TCW'(1);
  end
`else
  assign w_tail_iss  = 1'b0;
  assign w_tail_end  = 1'b0;
  assign w_last_step = w_acc && i_last;
  assign w_end_fsm   = IDLE;
`endif

  assign w_issue = w_acc || w_tail_iss;
  assign w_d     = w_tail_iss ? 2'b00 : i_data;

  conv_encoder_step #(.G0(G0), .G1(G1)) u_step (
    .i_state (r_enc_st),
    .i_d     (w_d),
    .o_step  (w_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_fsm <= IDLE;
    else      r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE, ENC: if (w_acc) w_fsm_nxt = i_last ? w_end_fsm : ENC;
      TAIL:      if (w_tail_end) w_fsm_nxt = IDLE;
      default:   w_fsm_nxt = IDLE;
    endcase
  end

  // Trellis state is forced to 0 at frame end so the next frame always starts from state 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_enc_st <= 8'h00;
    else if (w_issue) r_enc_st <= w_last_step ? 8'h00 : w_step.state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_code  <= 4'h0;
      r_last  <= 1'b0;
      r_state <= 8'h00;
    end else if (w_issue) begin
      r_valid <= 1'b1;
      r_code  <= w_step.code;
      r_last  <= w_last_step;
      r_state <= w_step.state;
    end else if (en_enc && i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  // The count restarts on the first step of a frame, so it still reads the frame length at o_last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_cnt <= 16'h0000;
    else if (w_issue) r_cnt <= (r_fsm == IDLE) ? 16'h0001 :
                               (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'h0001;
  end

  assign o_valid    = r_valid;
  assign o_code     = r_code;
  assign o_last     = r_last;
  assign o_state    = r_state;
  assign o_step_cnt = r_cnt;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder against a bit-serial shift-register reference model.
module tb_conv_encoder;

`ifdef CONV_TAIL_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif
  localparam logic [8:0] G0 = 9'o561;
  localparam logic [8:0] G1 = 9'o753;

  typedef struct packed {
    logic [3:0]  code;
    logic [7:0]  st;
    logic        last;
    logic [15:0] cnt;
  } item_t;

  logic        clk = 1'b0;
  logic        rst, en_enc, i_valid, i_last, i_ready;
  logic [1:0]  i_data;
  logic        o_ready, o_valid, o_last;
  logic [3:0]  o_code;
  logic [7:0]  o_state;
  logic [15:0] o_step_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit rand_bp = 1'b0;

  logic [1:0] data_q[$];
  item_t      exp_q[$];
  item_t      obs_q[$];

  conv_encoder dut (
    .clk(clk), .rst(rst), .en_enc(en_enc), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_code(o_code), .o_last(o_last), .o_state(o_state), .o_step_cnt(o_step_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Record every completed output handshake.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (rst && en_enc && o_valid && i_ready) begin
        it.code = o_code; it.st = o_state; it.last = o_last; it.cnt = o_step_cnt;
        obs_q.push_back(it);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_bp) i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Reference: feed bits one at a time through an 8-bit history; state is the last 8 bits.
  task automatic build_model();
    logic [7:0] h;
    logic [8:0] w;
    logic [1:0] d;
    item_t      it;
    int         n;
    h = 8'h00;
    n = data_q.size() + (TAIL_EN ? 4 : 0);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      d = (i < data_q.size()) ? data_q[i] : 2'b00;
      it.code = 4'h0;
      for (int b = 0; b < 2; b++) begin
        w = {h, d[b]};
        it.code[2*b]   = 1'($countones(w & G0) % 2);
        it.code[2*b+1] = 1'($countones(w & G1) % 2);
        h = {h[6:0], d[b]};
      end
      it.st = h; it.last = (i == n - 1); it.cnt = 16'(i + 1);
      exp_q.push_back(it);
    end
  endtask

  task automatic drive_step(input logic [1:0] d, input logic last);
    bit acc;
    i_valid = 1'b1; i_data = d; i_last = last;
    acc = 1'b0;
    for (int k = 0; k < 500 && !acc; k++) begin
      @(negedge clk); acc = o_ready;
      @(posedge clk); #1;
    end
    if (!acc) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: o_ready=0 for 500 cycles, required 1");
    end
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input bit gaps);
    for (int i = from; i < to; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      drive_step(data_q[i], i == data_q.size() - 1);
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000 && obs_q.size() < exp_q.size(); k++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic new_frame();
    data_q.delete(); exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; en_enc = 1'b1; i_valid = 1'b0; i_data = 2'b00; i_last = 1'b0; i_ready = 1'b1;
    #12;
    vectors++; if (o_valid !== 1'b0)    begin miscompares++; $display("FAIL reset_valid: got %b required 0", o_valid); end
    vectors++; if (o_state !== 8'h00)   begin miscompares++; $display("FAIL reset_state: got %h required 00", o_state); end
    vectors++; if (o_code !== 4'h0)     begin miscompares++; $display("FAIL reset_code: got %h required 0", o_code); end
    vectors++; if (o_step_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_cnt: got %0d required 0", o_step_cnt); end
    vectors++; if (o_ready !== 1'b0)    begin miscompares++; $display("FAIL reset_ready: got %b required 0", o_ready); end
    vectors++; if (o_last !== 1'b0)     begin miscompares++; $display("FAIL reset_last: got %b required 0", o_last); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    new_frame();
    data_q.push_back(2'b01);
    repeat (7) data_q.push_back(2'b00);
    build_model();
    send_range(0, data_q.size(), 1'b0);
    wait_done();
    vectors++;
    if (obs_q.size() == 0 || obs_q[0].code !== 4'b1011 || obs_q[0].st !== 8'h02) begin
      miscompares++;
      $display("FAIL impulse_first: got %h required code b and state 02", obs_q.size() ? obs_q[0] : '0);
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL impulse step %0d: got %h required %h", i, i < obs_q.size() ? obs_q[i] : '0, exp_q[i]);
      end
    end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL impulse_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_zero_frame();
    new_frame();
    repeat (10) data_q.push_back(2'b00);
    build_model();
    send_range(0, data_q.size(), 1'b0);
    wait_done();
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL zero step %0d: got %h required %h", i, i < obs_q.size() ? obs_q[i] : '0, exp_q[i]);
      end
    end
    vectors++;
    if (obs_q.size() == 0 || !obs_q[$].last || obs_q[$].cnt !== (TAIL_EN ? 16'd14 : 16'd10)) begin
      miscompares++;
      $display("FAIL zero_last_cnt: got %h required last=1 cnt=%0d", obs_q.size() ? obs_q[$] : '0, TAIL_EN ? 14 : 10);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] hc;
    logic [7:0] hs;
    new_frame();
    repeat (12) data_q.push_back(2'($urandom_range(0, 3)));
    build_model();
    send_range(0, 4, 1'b0);
    i_valid = 1'b1; i_data = data_q[4]; i_last = 1'b0; i_ready = 1'b0;
    @(negedge clk); hc = o_code; hs = o_state;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_code !== hc || o_state !== hs) begin
        miscompares++;
        $display("FAIL bp_hold cyc %0d: got rdy=%b vld=%b code=%h st=%h required rdy=0 vld=1 code=%h st=%h",
                 k, o_ready, o_valid, o_code, o_state, hc, hs);
      end
    end
    @(posedge clk); #1;
    i_ready = 1'b1;
    send_range(4, data_q.size(), 1'b0);
    wait_done();
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL bp step %0d: got %h required %h", i, i < obs_q.size() ? obs_q[i] : '0, exp_q[i]);
      end
    end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL bp_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_random_frame();
    new_frame();
    repeat (100) data_q.push_back(2'($urandom_range(0, 3)));
    build_model();
    rand_bp = 1'b1;
    send_range(0, data_q.size(), 1'b1);
    rand_bp = 1'b0;
    @(posedge clk); #1;
    i_ready = 1'b1;
    wait_done();
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL random step %0d: got %h required %h", i, i < obs_q.size() ? obs_q[i] : '0, exp_q[i]);
      end
    end
    vectors++;
    if (obs_q.size() != (TAIL_EN ? 104 : 100)) begin
      miscompares++;
      $display("FAIL random_len: got %0d required %0d", obs_q.size(), TAIL_EN ? 104 : 100);
    end
  endtask

  task automatic test_freeze_reset();
    logic        hv;
    logic [3:0]  hc;
    logic [7:0]  hs;
    logic [15:0] hn;
    int          stop;
    stop = TAIL_EN ? 6 : 3;
    // Freeze: in the tail when enabled, otherwise mid-frame.
    new_frame();
    repeat (6) data_q.push_back(2'($urandom_range(0, 3)));
    build_model();
    send_range(0, stop, 1'b0);
    en_enc = 1'b0;
    @(negedge clk); hv = o_valid; hc = o_code; hs = o_state; hn = o_step_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (o_valid !== hv || o_code !== hc || o_state !== hs || o_step_cnt !== hn || o_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL freeze cyc %0d: got vld=%b code=%h st=%h cnt=%0d rdy=%b required vld=%b code=%h st=%h cnt=%0d rdy=0",
                 k, o_valid, o_code, o_state, o_step_cnt, o_ready, hv, hc, hs, hn);
      end
    end
    @(posedge clk); #1;
    en_enc = 1'b1;
    send_range(stop, data_q.size(), 1'b0);
    wait_done();
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL freeze step %0d: got %h required %h", i, i < obs_q.size() ? obs_q[i] : '0, exp_q[i]);
      end
    end
    // Async reset in the middle of a frame.
    new_frame();
    repeat (6) data_q.push_back(2'($urandom_range(1, 3)));
    send_range(0, stop, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (o_valid !== 1'b0 || o_state !== 8'h00 || o_code !== 4'h0 || o_step_cnt !== 16'h0 || o_last !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset: got vld=%b st=%h code=%h cnt=%0d last=%b required all 0",
               o_valid, o_state, o_code, o_step_cnt, o_last);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    new_frame();
    data_q.push_back(2'b01);
    repeat (3) data_q.push_back(2'($urandom_range(0, 3)));
    build_model();
    send_range(0, data_q.size(), 1'b0);
    wait_done();
    vectors++;
    if (obs_q.size() == 0 || obs_q[0].code !== 4'b1011 || obs_q[0].st !== 8'h02 || obs_q[0].cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL post_reset_first: got %h required code b state 02 cnt 1", obs_q.size() ? obs_q[0] : '0);
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL post_reset step %0d: got %h required %h", i, i < obs_q.size() ? obs_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_zero_frame();
    test_backpressure();
    test_random_frame();
    test_freeze_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
